sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_controller.sv | 141 ++++++++++++++
 tb/tb_sram_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM controller: FSM state encoding, bus widths,
// the SRAM window base address and the byte-to-word address helper.
package sram_pkg;

    localparam int SRAM_BASE_ADDR = 1024;
    localparam int SRAM_ADDR_W    = 18;
    localparam int SRAM_DATA_W    = 16;
    localparam int CPU_DATA_W     = 32;
    localparam int WORD_ADDR_W    = SRAM_ADDR_W - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // CPU byte address -> 32-bit word index inside the SRAM window.
    // Addresses below the base wrap around the 17-bit word space.
    function automatic logic [WORD_ADDR_W-1:0] word_addr(input logic [31:0] byte_addr);
        return WORD_ADDR_W'((byte_addr - 32'(SRAM_BASE_ADDR)) >> 2);
    endfunction

endpackage

// File: rtl/sram_controller.sv
// SRAM controller: turns one 32-bit CPU word access into two 16-bit SRAM
// half-word cycles (low half first, then high half).
// Optional macro SRAM_WAIT_STATE_EN stretches each half-word phase to two
// clock cycles; without it every phase is a single cycle.
module sram_controller
    import sram_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_R_EN,
    input  logic                   MEM_W_EN,
    input  logic [31:0]            address,
    input  logic [CPU_DATA_W-1:0]  wdata,
    output logic [CPU_DATA_W-1:0]  rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    input  logic [SRAM_DATA_W-1:0] SRAM_DQ_in,
    output logic [SRAM_DATA_W-1:0] SRAM_DQ_out,
    output logic                   SRAM_DQ_oe,
    output logic                   SRAM_WE_N
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [WORD_ADDR_W-1:0]  r_word_addr;
    logic [CPU_DATA_W-1:0]   r_wdata;
    logic                    r_is_write;
    logic [CPU_DATA_W-1:0]   r_rdata;
    logic                    w_req;
    logic                    w_phase_last;

    // A combined read+write request is treated as a write.
    assign w_req = MEM_R_EN | MEM_W_EN;

`ifdef SRAM_WAIT_STATE_EN
    logic r_wait;

    // Wait counter: toggles through the two cycles of each LOW/HIGH phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= 1'b0;
        end else if ((r_state == ST_LOW) || (r_state == ST_HIGH)) begin
            r_wait <= ~r_wait;
        end else begin
            r_wait <= 1'b0;
        end
    end

    assign w_phase_last = r_wait;
`else
    assign w_phase_last = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; DONE always returns to IDLE so a held request
    // cannot retrigger the access it just completed.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req)        w_state_next = ST_LOW;
            ST_LOW:  if (w_phase_last) w_state_next = ST_HIGH;
            ST_HIGH: if (w_phase_last) w_state_next = ST_DONE;
            ST_DONE:                   w_state_next = ST_IDLE;
            default:                   w_state_next = ST_IDLE;
        endcase
    end

    // Output decode: bus address, write strobe and data drive per state.
    always_comb begin
        ready       = 1'b0;
        SRAM_ADDR   = '0;
        SRAM_DQ_out = '0;
        SRAM_DQ_oe  = 1'b0;
        SRAM_WE_N   = 1'b1;
        case (r_state)
            ST_IDLE: begin
                ready = ~w_req;
            end
            ST_LOW: begin
                SRAM_ADDR = {r_word_addr, 1'b0};
                if (r_is_write) begin
                    SRAM_DQ_out = r_wdata[SRAM_DATA_W-1:0];
                    SRAM_DQ_oe  = 1'b1;
                    SRAM_WE_N   = 1'b0;
                end
            end
            ST_HIGH: begin
                SRAM_ADDR = {r_word_addr, 1'b1};
                if (r_is_write) begin
                    SRAM_DQ_out = r_wdata[CPU_DATA_W-1:SRAM_DATA_W];
                    SRAM_DQ_oe  = 1'b1;
                    SRAM_WE_N   = 1'b0;
                end
            end
            ST_DONE: begin
                ready = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    // Request capture: address, store data and direction are frozen at the
    // IDLE->LOW transition so the CPU may drop or change them mid-access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_addr <= '0;
            r_wdata     <= '0;
            r_is_write  <= 1'b0;
        end else if ((r_state == ST_IDLE) && w_req) begin
            r_word_addr <= word_addr(address);
            r_wdata     <= wdata;
            r_is_write  <= MEM_W_EN;
        end
    end

    // Read data capture at the end of each half-word phase; holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (!r_is_write && w_phase_last) begin
            if (r_state == ST_LOW) begin
                r_rdata[SRAM_DATA_W-1:0] <= SRAM_DQ_in;
            end else if (r_state == ST_HIGH) begin
                r_rdata[CPU_DATA_W-1:SRAM_DATA_W] <= SRAM_DQ_in;
            end
        end
    end

    assign rdata = r_rdata;

endmodule

// File: tb/tb_sram_controller.sv
// Testbench for sram_controller: table of directed word accesses against a
// small behavioural SRAM, plus hand sequences for back-to-back and reset.
module tb_sram_controller;
    import sram_pkg::*;

`ifdef SRAM_WAIT_STATE_EN
    localparam int PH = 2;
`else
    localparam int PH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        MEM_R_EN;
    logic        MEM_W_EN;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] SRAM_ADDR;
    logic [15:0] SRAM_DQ_in;
    logic [15:0] SRAM_DQ_out;
    logic        SRAM_DQ_oe;
    logic        SRAM_WE_N;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sram_controller dut (
        .clk         (clk),
        .rst         (rst),
        .MEM_R_EN    (MEM_R_EN),
        .MEM_W_EN    (MEM_W_EN),
        .address     (address),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_DQ_in  (SRAM_DQ_in),
        .SRAM_DQ_out (SRAM_DQ_out),
        .SRAM_DQ_oe  (SRAM_DQ_oe),
        .SRAM_WE_N   (SRAM_WE_N)
    );

    // Behavioural SRAM, indexed by the low 10 address bits.
    logic [15:0] mem [0:1023];
    logic        model_init;

    always @(posedge clk) begin
        if (model_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
            mem[2] <= 16'h5678;
            mem[3] <= 16'h1234;
        end else if (!SRAM_WE_N && SRAM_DQ_oe) begin
            mem[SRAM_ADDR[9:0]] <= SRAM_DQ_out;
        end
    end

    assign SRAM_DQ_in = mem[SRAM_ADDR[9:0]];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        hold;
        logic [17:0] exp_lo;
        logic [17:0] exp_hi;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one access starting in IDLE (called #1 after a rising edge).
    // Returns at the falling edge of the DONE cycle.
    task automatic do_access(input vec_t v, input int idx);
        logic [15:0] exp_dq;
        MEM_R_EN = v.rd;
        MEM_W_EN = v.wr;
        address  = v.addr;
        wdata    = v.wdata;
        @(negedge clk);
        chk($sformatf("v%0d req_ready", idx), {31'b0, ready}, 32'd0);
        chk($sformatf("v%0d idle_addr", idx), {14'b0, SRAM_ADDR}, 32'd0);
        for (int ph = 0; ph < 2; ph++) begin
            for (int w = 0; w < PH; w++) begin
                @(posedge clk);
                #1;
                if (!v.hold) begin
                    MEM_R_EN = 1'b0;
                    MEM_W_EN = 1'b0;
                    address  = 32'hFFFF_FFF0;
                    wdata    = 32'h0;
                end
                @(negedge clk);
                exp_dq = !v.wr ? 16'h0 : (ph == 1 ? v.wdata[31:16] : v.wdata[15:0]);
                chk($sformatf("v%0d p%0d.%0d addr", idx, ph, w), {14'b0, SRAM_ADDR},
                    {14'b0, (ph == 1 ? v.exp_hi : v.exp_lo)});
                chk($sformatf("v%0d p%0d.%0d we_n", idx, ph, w), {31'b0, SRAM_WE_N}, {31'b0, ~v.wr});
                chk($sformatf("v%0d p%0d.%0d oe", idx, ph, w), {31'b0, SRAM_DQ_oe}, {31'b0, v.wr});
                chk($sformatf("v%0d p%0d.%0d dq_out", idx, ph, w), {16'b0, SRAM_DQ_out}, {16'b0, exp_dq});
                chk($sformatf("v%0d p%0d.%0d busy", idx, ph, w), {31'b0, ready}, 32'd0);
            end
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        chk($sformatf("v%0d done_ready", idx), {31'b0, ready}, 32'd1);
        chk($sformatf("v%0d done_we_n", idx), {31'b0, SRAM_WE_N}, 32'd1);
        chk($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
        $display("[TB] txn %0d rd=%0b wr=%0b addr=%h wdata=%h -> rdata=%h ready=%0b",
                 idx, v.rd, v.wr, v.addr, v.wdata, rdata, ready);
    endtask

    // Leaves DONE, drops the request and confirms the controller is idle.
    task automatic finish_idle(input int idx);
        @(posedge clk);
        #1;
        MEM_R_EN = 1'b0;
        MEM_W_EN = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d idle_ready", idx), {31'b0, ready}, 32'd1);
        chk($sformatf("v%0d idle_addr_after", idx), {14'b0, SRAM_ADDR}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            rd    wr    addr          wdata          hold  lo        hi        rdata
        vecs[0] = '{1'b0, 1'b1, 32'd1024,     32'hDEADBEEF, 1'b1, 18'h0,    18'h1,    32'h0000_0000};
        vecs[1] = '{1'b1, 1'b0, 32'd1028,     32'h0,        1'b1, 18'h2,    18'h3,    32'h1234_5678};
        vecs[2] = '{1'b1, 1'b1, 32'd1032,     32'hCAFEF00D, 1'b0, 18'h4,    18'h5,    32'h1234_5678};
        vecs[3] = '{1'b1, 1'b0, 32'd1024,     32'h0,        1'b0, 18'h0,    18'h1,    32'hDEAD_BEEF};
        vecs[4] = '{1'b1, 1'b0, 32'd1032,     32'h0,        1'b1, 18'h4,    18'h5,    32'hCAFE_F00D};
        vecs[5] = '{1'b0, 1'b1, 32'd1020,     32'h0BADC0DE, 1'b1, 18'h3FFFE, 18'h3FFFF, 32'hCAFE_F00D};
        vecs[6] = '{1'b1, 1'b0, 32'd1020,     32'h0,        1'b1, 18'h3FFFE, 18'h3FFFF, 32'h0BAD_C0DE};
        vecs[7] = '{1'b0, 1'b1, 32'd1424,     32'hA5A55A5A, 1'b0, 18'hC8,   18'hC9,   32'h0BAD_C0DE};
        vecs[8] = '{1'b1, 1'b0, 32'd1427,     32'h0,        1'b1, 18'hC8,   18'hC9,   32'hA5A5_5A5A};
        vecs[9] = '{1'b1, 1'b0, 32'h8000_0400, 32'h0,       1'b1, 18'h0,    18'h1,    32'hDEAD_BEEF};

        rst        = 1'b1;
        model_init = 1'b1;
        MEM_R_EN   = 1'b0;
        MEM_W_EN   = 1'b0;
        address    = 32'h0;
        wdata      = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst        = 1'b0;
        model_init = 1'b0;
        @(negedge clk);
        chk("reset ready", {31'b0, ready}, 32'd1);
        chk("reset rdata", rdata, 32'd0);
        chk("reset we_n", {31'b0, SRAM_WE_N}, 32'd1);
        chk("reset oe", {31'b0, SRAM_DQ_oe}, 32'd0);
        chk("reset addr", {14'b0, SRAM_ADDR}, 32'd0);
        chk("reset dq_out", {16'b0, SRAM_DQ_out}, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) begin
            do_access(vecs[i], i);
            finish_idle(i);
        end

        // Back-to-back reads: request held through DONE, next address applied
        // in IDLE; the second access must go to the new address.
        begin
            vec_t b0;
            vec_t b1;
            b0 = '{1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, 18'h0, 18'h1, 32'hDEAD_BEEF};
            b1 = '{1'b1, 1'b0, 32'd1028, 32'h0, 1'b1, 18'h2, 18'h3, 32'h1234_5678};
            do_access(b0, 10);
            @(posedge clk);
            #1;
            do_access(b1, 11);
            finish_idle(11);
        end

        // Reset during the high-half phase of a write.
        MEM_W_EN = 1'b1;
        address  = 32'd1024;
        wdata    = 32'h1111_2222;
        for (int c = 0; c < 1 + PH; c++) begin
            @(posedge clk);
            #1;
            MEM_W_EN = 1'b0;
        end
        @(negedge clk);
        chk("rstmid high addr", {14'b0, SRAM_ADDR}, 32'd1);
        chk("rstmid high we_n", {31'b0, SRAM_WE_N}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid ready", {31'b0, ready}, 32'd1);
        chk("rstmid we_n", {31'b0, SRAM_WE_N}, 32'd1);
        chk("rstmid oe", {31'b0, SRAM_DQ_oe}, 32'd0);
        chk("rstmid addr", {14'b0, SRAM_ADDR}, 32'd0);
        chk("rstmid rdata", rdata, 32'd0);
        $display("[TB] txn reset-in-HIGH -> ready=%0b we_n=%0b rdata=%h", ready, SRAM_WE_N, rdata);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rstmid stay idle", {31'b0, ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
